// File: rtl/shift_reg_unit_pkg.sv
// Shared constants for shift_reg_unit: mode encoding and default sizes.
package shift_reg_unit_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_reg_unit_if.sv
// Bundle of the shift register's control inputs and outputs; clk/rst stay outside.
interface shift_reg_unit_if
    import shift_reg_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             slow_clk;
    logic [1:0]       mode;
    logic             ser_in_r;
    logic             ser_in_l;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             step;
    logic [CNT_W-1:0] shift_cnt;

    modport master (
        output slow_clk, mode, ser_in_r, ser_in_l, load_val,
        input  q, step, shift_cnt
    );

    modport slave (
        input  slow_clk, mode, ser_in_r, ser_in_l, load_val,
        output q, step, shift_cnt
    );

endinterface

// File: rtl/shift_reg_unit_edge_sync.sv
// edge_sync: three-flop synchroniser with a one-cycle rising-edge pulse.
// Reset parks all flops high so a signal already high at reset never pulses.
module edge_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // s1 is the metastability catcher; the edge is judged on the settled s2/s3 pair.
    assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/shift_reg_unit.sv
// shift_reg_unit: shift register stepped once per rising edge of slow_clk.
// Define SHIFT_REG_UNIT_ROTATE_EN to make the shift modes rotate instead of using serial inputs.
module shift_reg_unit
    import shift_reg_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst,
    shift_reg_unit_if.slave  bus
);

    logic             step;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shl_in, shr_in;

    edge_sync u_edge_sync (
        .clk_in     (clk_in),
        .rst        (rst),
        .async_in   (bus.slow_clk),
        .rise_pulse (step)
    );

`ifdef SHIFT_REG_UNIT_ROTATE_EN
    logic unused_ser;
    assign unused_ser = bus.ser_in_r ^ bus.ser_in_l;
    assign shl_in     = q_q[WIDTH-1];
    assign shr_in     = q_q[0];
`else
    assign shl_in     = bus.ser_in_r;
    assign shr_in     = bus.ser_in_l;
`endif

    // Inputs are only looked at in the step cycle; otherwise state holds.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (step) begin
            case (bus.mode)
                MODE_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], shl_in};
                    cnt_d = cnt_q + 1'b1;
                end
                MODE_SHR: begin
                    q_d   = {shr_in, q_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = bus.load_val;
                    cnt_d = '0;
                end
                default: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.step      = step;
    assign bus.shift_cnt = cnt_q;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Directed bench for shift_reg_unit (WIDTH=8, CNT_W=8); honours SHIFT_REG_UNIT_ROTATE_EN.
module tb_shift_reg_unit;
    import shift_reg_unit_pkg::*;

    localparam int W  = 8;
    localparam int CW = 8;

    logic clk_in = 1'b0;
    logic rst;
    always #5 clk_in = ~clk_in;

    shift_reg_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_reg_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [1:0] mode;
        logic       sr;
        logic       sl;
        logic [7:0] lv;
        logic [7:0] exp_q;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full slow_clk period: low phase with junk inputs, then a rise with the real ones.
    task automatic do_rise(input logic [1:0] m, input logic sr, input logic sl,
                           input logic [7:0] lv, input logic [7:0] eq, input logic [7:0] ecnt,
                           input string name, input bit checked);
        logic [7:0] q0, q1;
        logic       s0, s1, s2;
        int         steps;
        steps = 0;
        @(negedge clk_in);
        q0           = bus.q;
        bus.slow_clk = 1'b0;
        bus.mode     = MODE_LOAD;
        bus.load_val = ~q0;
        bus.ser_in_r = 1'($urandom);
        bus.ser_in_l = 1'($urandom);
        repeat (4) begin
            @(negedge clk_in);
            steps += int'(bus.step);
        end
        if (checked) begin
            chk({name, " idle q"}, 32'(bus.q), 32'(q0));
            chk({name, " idle step"}, 32'(steps), 32'd0);
        end
        bus.mode     = m;
        bus.ser_in_r = sr;
        bus.ser_in_l = sl;
        bus.load_val = lv;
        bus.slow_clk = 1'b1;
        @(negedge clk_in); s0 = bus.step;
        @(negedge clk_in); s1 = bus.step; q1 = bus.q;
        @(negedge clk_in); s2 = bus.step;
        if (checked) begin
            chk({name, " step pulse"}, 32'({s0, s1, s2}), 32'(3'b010));
            chk({name, " q before E2"}, 32'(q1), 32'(q0));
            chk({name, " q"}, 32'(bus.q), 32'(eq));
            chk({name, " cnt"}, 32'(bus.shift_cnt), 32'(ecnt));
        end
    endtask

    initial begin
        int steps;
        rst          = 1'b1;
        bus.slow_clk = 1'b1;
        bus.mode     = MODE_HOLD;
        bus.ser_in_r = 1'b0;
        bus.ser_in_l = 1'b0;
        bus.load_val = 8'h00;

`ifdef SHIFT_REG_UNIT_ROTATE_EN
        vecs[0] = '{MODE_LOAD, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'd0};
        vecs[1] = '{MODE_SHL,  1'b1, 1'b0, 8'h00, 8'h4B, 8'd1};
        vecs[2] = '{MODE_SHL,  1'b1, 1'b0, 8'h00, 8'h96, 8'd2};
        vecs[3] = '{MODE_LOAD, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'd0};
        vecs[4] = '{MODE_SHR,  1'b0, 1'b0, 8'h00, 8'hD2, 8'd1};
        vecs[5] = '{MODE_HOLD, 1'b1, 1'b1, 8'hFF, 8'hD2, 8'd1};
        vecs[6] = '{MODE_HOLD, 1'b0, 1'b1, 8'h3C, 8'hD2, 8'd1};
        vecs[7] = '{MODE_HOLD, 1'b1, 1'b0, 8'h00, 8'hD2, 8'd1};
`else
        vecs[0] = '{MODE_LOAD, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'd0};
        vecs[1] = '{MODE_SHL,  1'b1, 1'b0, 8'h00, 8'h4B, 8'd1};
        vecs[2] = '{MODE_SHL,  1'b1, 1'b0, 8'h00, 8'h97, 8'd2};
        vecs[3] = '{MODE_LOAD, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'd0};
        vecs[4] = '{MODE_SHR,  1'b0, 1'b0, 8'h00, 8'h52, 8'd1};
        vecs[5] = '{MODE_HOLD, 1'b1, 1'b1, 8'hFF, 8'h52, 8'd1};
        vecs[6] = '{MODE_HOLD, 1'b0, 1'b1, 8'h3C, 8'h52, 8'd1};
        vecs[7] = '{MODE_HOLD, 1'b1, 1'b0, 8'h00, 8'h52, 8'd1};
`endif

        // Reset with slow_clk high, then 20 idle cycles: no step may appear.
        repeat (3) @(negedge clk_in);
        chk("reset q", 32'(bus.q), 32'h0);
        chk("reset cnt", 32'(bus.shift_cnt), 32'h0);
        chk("reset step", 32'(bus.step), 32'h0);
        rst   = 1'b0;
        steps = 0;
        repeat (20) begin
            @(negedge clk_in);
            steps += int'(bus.step);
        end
        chk("post-reset high steps", 32'(steps), 32'd0);
        chk("post-reset q", 32'(bus.q), 32'h0);
        chk("post-reset cnt", 32'(bus.shift_cnt), 32'h0);

        for (int i = 0; i < 8; i++) begin
            do_rise(vecs[i].mode, vecs[i].sr, vecs[i].sl, vecs[i].lv,
                    vecs[i].exp_q, vecs[i].exp_cnt, $sformatf("vec%0d", i), 1'b1);
        end

        // Counter wrap: 255 shifts from 0x01, then one more.
        do_rise(MODE_LOAD, 1'b0, 1'b0, 8'h01, 8'h01, 8'd0, "wrap load", 1'b1);
        for (int i = 0; i < 255; i++) begin
            do_rise(MODE_SHL, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, "bulk", 1'b0);
        end
        chk("wrap cnt 255", 32'(bus.shift_cnt), 32'd255);
`ifdef SHIFT_REG_UNIT_ROTATE_EN
        chk("wrap q 255", 32'(bus.q), 32'h80);
        do_rise(MODE_SHL, 1'b1, 1'b0, 8'h00, 8'h01, 8'd0, "wrap", 1'b1);
`else
        chk("wrap q 255", 32'(bus.q), 32'hFF);
        do_rise(MODE_SHL, 1'b1, 1'b0, 8'h00, 8'hFF, 8'd0, "wrap", 1'b1);
`endif

        // Reset landing in the step cycle must swallow the step.
        do_rise(MODE_LOAD, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'd0, "pre-rst load", 1'b1);
        @(negedge clk_in);
        bus.slow_clk = 1'b0;
        bus.mode     = MODE_SHL;
        bus.ser_in_r = 1'b1;
        repeat (4) @(negedge clk_in);
        bus.slow_clk = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rst-step step high", 32'(bus.step), 32'h1);
        rst = 1'b1;
        @(negedge clk_in);
        chk("rst-step q", 32'(bus.q), 32'h0);
        chk("rst-step cnt", 32'(bus.shift_cnt), 32'h0);
        chk("rst-step step", 32'(bus.step), 32'h0);
        rst   = 1'b0;
        steps = 0;
        repeat (10) begin
            @(negedge clk_in);
            steps += int'(bus.step);
        end
        chk("rst-step no late step", 32'(steps), 32'd0);
        chk("rst-step q held", 32'(bus.q), 32'h0);
`ifdef SHIFT_REG_UNIT_ROTATE_EN
        do_rise(MODE_SHL, 1'b1, 1'b0, 8'h00, 8'h00, 8'd1, "after rst", 1'b1);
`else
        do_rise(MODE_SHL, 1'b1, 1'b0, 8'h00, 8'h01, 8'd1, "after rst", 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
